// File: rtl/io_register_controller.sv
// Peripheral register block for the CPU bus: button debouncing, vblank/collision
// event latching, frame counter, and forwarding of non-local writes to the display.
module io_register_controller #(
    parameter int unsigned              DEBOUNCE_W     = 16,
    parameter logic [DEBOUNCE_W-1:0]    DEBOUNCE_RESET = 16'd25000,
    parameter logic [11:0]              LOCAL_LIMIT    = 12'd8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] register_index,
    input  logic        register_read,
    input  logic        register_write,
    input  logic [15:0] register_write_value,
    output logic [15:0] register_read_value,
    input  logic [3:0]  buttons_i,
    input  logic        in_vblank_i,
    input  logic [5:0]  collision_i,
    output logic        dc_register_write_o,
    output logic [11:0] dc_register_index_o,
    output logic [15:0] dc_register_write_value_o
);

    localparam logic [11:0] REG_BUTTONS   = 12'd0;
    localparam logic [11:0] REG_PRESS     = 12'd1;
    localparam logic [11:0] REG_VBLANK    = 12'd2;
    localparam logic [11:0] REG_COLLISION = 12'd3;
    localparam logic [11:0] REG_FRAME     = 12'd4;
    localparam logic [11:0] REG_DEBOUNCE  = 12'd5;

    localparam logic [DEBOUNCE_W-1:0] CNT_ONE = DEBOUNCE_W'(1);

    // Bus protocol: register_read / register_write are single-cycle valids with no
    // back-pressure (always ready); reads answer one edge later, forwarded writes
    // appear as a one-cycle dc_register_write_o valid the edge after acceptance.

    // Address decode
    logic local_sel;
    logic rd_local;
    logic wr_local;
    logic wr_fwd;

    assign local_sel = (register_index < LOCAL_LIMIT);
    assign rd_local  = register_read  && local_sel;
    assign wr_local  = register_write && local_sel;
    assign wr_fwd    = register_write && !local_sel;

    logic clr_press;
    logic clr_vblank;
    logic clr_collision;

    assign clr_press     = rd_local && (register_index == REG_PRESS);
    assign clr_vblank    = rd_local && (register_index == REG_VBLANK);
    assign clr_collision = rd_local && (register_index == REG_COLLISION);

    // State registers
    logic [3:0]                   btn_meta_q, btn_sync_q;
    logic [3:0]                   stable_q, stable_d;
    logic [3:0][DEBOUNCE_W-1:0]   cnt_q, cnt_d;
    logic [3:0]                   press_q, press_d;
    logic [DEBOUNCE_W-1:0]        period_q, period_d;
    logic [DEBOUNCE_W-1:0]        period_eff;

    logic                         vb_meta_q, vb_sync_q, vb_dly_q;
    logic                         vb_rise;
    logic                         vb_start_q, vb_start_d;
    logic [5:0]                   coll_q, coll_d;
    logic [15:0]                  frame_q, frame_d;

    logic [15:0]                  read_value_q, read_value_d;
    logic [15:0]                  read_mux;
    logic                         fwd_write_q, fwd_write_d;
    logic [11:0]                  fwd_index_q, fwd_index_d;
    logic [15:0]                  fwd_data_q, fwd_data_d;

    // Debounce: a period of 0 counts as 1 so a zero write cannot freeze the buttons
    always_comb begin
        period_eff = (period_q == '0) ? CNT_ONE : period_q;
        stable_d   = stable_q;
        cnt_d      = '0;
        for (int i = 0; i < 4; i++) begin
            if (btn_sync_q[i] != stable_q[i]) begin
                if (cnt_q[i] >= period_eff - CNT_ONE) begin
                    stable_d[i] = btn_sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    assign vb_rise = vb_sync_q && !vb_dly_q;

    // Sticky events: a set in the same cycle as the clearing read wins
    always_comb begin
        press_d    = (press_q & ~{4{clr_press}}) | (stable_d & ~stable_q);
        vb_start_d = (vb_start_q && !clr_vblank) || vb_rise;
        coll_d     = (coll_q & ~{6{clr_collision}}) | collision_i;
    end

    always_comb begin
        frame_d  = frame_q;
        period_d = period_q;
        if (wr_local && (register_index == REG_FRAME)) begin
            frame_d = register_write_value;
        end else if (vb_rise) begin
            frame_d = frame_q + 16'd1;
        end
        if (wr_local && (register_index == REG_DEBOUNCE)) begin
            period_d = DEBOUNCE_W'(register_write_value);
        end
    end

    always_comb begin
        read_mux = '0;
        if (local_sel) begin
            case (register_index)
                REG_BUTTONS:   read_mux = {12'd0, stable_q};
                REG_PRESS:     read_mux = {12'd0, press_q};
                REG_VBLANK:    read_mux = {14'd0, vb_start_q, vb_sync_q};
                REG_COLLISION: read_mux = {10'd0, coll_q};
                REG_FRAME:     read_mux = frame_q;
                REG_DEBOUNCE:  read_mux = 16'(period_q);
                default:       read_mux = '0;
            endcase
        end
        read_value_d = register_read ? read_mux : read_value_q;
    end

    always_comb begin
        fwd_write_d = wr_fwd;
        fwd_index_d = wr_fwd ? register_index       : fwd_index_q;
        fwd_data_d  = wr_fwd ? register_write_value : fwd_data_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_meta_q   <= '0;
            btn_sync_q   <= '0;
            stable_q     <= '0;
            cnt_q        <= '0;
            press_q      <= '0;
            period_q     <= DEBOUNCE_RESET;
            vb_meta_q    <= 1'b0;
            vb_sync_q    <= 1'b0;
            vb_dly_q     <= 1'b0;
            vb_start_q   <= 1'b0;
            coll_q       <= '0;
            frame_q      <= '0;
            read_value_q <= '0;
            fwd_write_q  <= 1'b0;
            fwd_index_q  <= '0;
            fwd_data_q   <= '0;
        end else begin
            btn_meta_q   <= buttons_i;
            btn_sync_q   <= btn_meta_q;
            stable_q     <= stable_d;
            cnt_q        <= cnt_d;
            press_q      <= press_d;
            period_q     <= period_d;
            vb_meta_q    <= in_vblank_i;
            vb_sync_q    <= vb_meta_q;
            vb_dly_q     <= vb_sync_q;
            vb_start_q   <= vb_start_d;
            coll_q       <= coll_d;
            frame_q      <= frame_d;
            read_value_q <= read_value_d;
            fwd_write_q  <= fwd_write_d;
            fwd_index_q  <= fwd_index_d;
            fwd_data_q   <= fwd_data_d;
        end
    end

    assign register_read_value       = read_value_q;
    assign dc_register_write_o       = fwd_write_q;
    assign dc_register_index_o       = fwd_index_q;
    assign dc_register_write_value_o = fwd_data_q;

endmodule

// File: tb/tb_io_register_controller.sv
// Directed bench for io_register_controller: register-access vector table plus
// hand-written sequences for debounce, vblank, collision, forwarding and reset.
module tb_io_register_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] register_index;
    logic        register_read;
    logic        register_write;
    logic [15:0] register_write_value;
    logic [15:0] register_read_value;
    logic [3:0]  buttons_i;
    logic        in_vblank_i;
    logic [5:0]  collision_i;
    logic        dc_register_write_o;
    logic [11:0] dc_register_index_o;
    logic [15:0] dc_register_write_value_o;

    io_register_controller dut (
        .clk                       (clk),
        .reset_n                   (reset_n),
        .register_index            (register_index),
        .register_read             (register_read),
        .register_write            (register_write),
        .register_write_value      (register_write_value),
        .register_read_value       (register_read_value),
        .buttons_i                 (buttons_i),
        .in_vblank_i               (in_vblank_i),
        .collision_i               (collision_i),
        .dc_register_write_o       (dc_register_write_o),
        .dc_register_index_o       (dc_register_index_o),
        .dc_register_write_value_o (dc_register_write_value_o)
    );

    // 25 MHz
    always #20 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Expected forwarded writes, {index, data}
    logic [27:0] exp_q[$];
    logic [27:0] fwd_exp;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [11:0] idx;
        logic [15:0] wdata;
        logic        chk_rd;
        logic [15:0] exp_rd;
        logic        exp_fwd;
    } vec_t;

    localparam int NVEC = 27;
    vec_t vecs[NVEC];

    function automatic vec_t mk(input logic rd, input logic wr, input logic [11:0] idx,
                                input logic [15:0] wdata, input logic chk_rd,
                                input logic [15:0] exp_rd, input logic exp_fwd);
        vec_t v;
        v.rd = rd; v.wr = wr; v.idx = idx; v.wdata = wdata;
        v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_fwd = exp_fwd;
        return v;
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [11:0] idx, output logic [15:0] val);
        register_index = idx;
        register_read  = 1'b1;
        tick();
        register_read  = 1'b0;
        val = register_read_value;
    endtask

    task automatic rd_check(input string name, input logic [11:0] idx, input logic [15:0] exp);
        logic [15:0] v;
        do_read(idx, v);
        check16(name, v, exp);
    endtask

    task automatic do_write(input logic [11:0] idx, input logic [15:0] val);
        register_index       = idx;
        register_write_value = val;
        register_write       = 1'b1;
        tick();
        register_write       = 1'b0;
    endtask

    // Forward monitor: every strobe must match the next expected write, and only once
    always @(negedge clk) begin
        if (reset_n && dc_register_write_o) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL fwd_unexpected: got idx 0x%03h data 0x%04h, expected no strobe",
                         dc_register_index_o, dc_register_write_value_o);
            end else begin
                fwd_exp = exp_q.pop_front();
                if ({dc_register_index_o, dc_register_write_value_o} !== fwd_exp) begin
                    n_fail++;
                    $display("FAIL fwd_payload: got 0x%07h, expected 0x%07h",
                             {dc_register_index_o, dc_register_write_value_o}, fwd_exp);
                end
            end
        end
    end

    initial begin
        logic [15:0] v;

        vecs[0]  = mk(1'b1, 1'b0, 12'h000, 16'h0000, 1'b1, 16'h0000, 1'b0);
        vecs[1]  = mk(1'b1, 1'b0, 12'h001, 16'h0000, 1'b1, 16'h0000, 1'b0);
        vecs[2]  = mk(1'b1, 1'b0, 12'h002, 16'h0000, 1'b1, 16'h0000, 1'b0);
        vecs[3]  = mk(1'b1, 1'b0, 12'h003, 16'h0000, 1'b1, 16'h0000, 1'b0);
        vecs[4]  = mk(1'b1, 1'b0, 12'h004, 16'h0000, 1'b1, 16'h0000, 1'b0);
        vecs[5]  = mk(1'b1, 1'b0, 12'h005, 16'h0000, 1'b1, 16'h61A8, 1'b0);
        vecs[6]  = mk(1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 16'h61A8, 1'b0); // hold
        vecs[7]  = mk(1'b1, 1'b0, 12'h006, 16'h0000, 1'b1, 16'h0000, 1'b0);
        vecs[8]  = mk(1'b1, 1'b0, 12'h005, 16'h0000, 1'b1, 16'h61A8, 1'b0);
        vecs[9]  = mk(1'b1, 1'b0, 12'h007, 16'h0000, 1'b1, 16'h0000, 1'b0);
        vecs[10] = mk(1'b1, 1'b0, 12'h005, 16'h0000, 1'b1, 16'h61A8, 1'b0);
        vecs[11] = mk(1'b1, 1'b0, 12'h008, 16'h0000, 1'b1, 16'h0000, 1'b0);
        vecs[12] = mk(1'b0, 1'b1, 12'h004, 16'h1234, 1'b0, 16'h0000, 1'b0);
        vecs[13] = mk(1'b1, 1'b0, 12'h004, 16'h0000, 1'b1, 16'h1234, 1'b0);
        vecs[14] = mk(1'b1, 1'b1, 12'h004, 16'h5678, 1'b1, 16'h1234, 1'b0);
        vecs[15] = mk(1'b1, 1'b0, 12'h004, 16'h0000, 1'b1, 16'h5678, 1'b0);
        vecs[16] = mk(1'b0, 1'b1, 12'h007, 16'hFFFF, 1'b0, 16'h0000, 1'b0);
        vecs[17] = mk(1'b0, 1'b1, 12'h008, 16'h0ABC, 1'b0, 16'h0000, 1'b1);
        vecs[18] = mk(1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        vecs[19] = mk(1'b0, 1'b1, 12'h000, 16'h000F, 1'b0, 16'h0000, 1'b0);
        vecs[20] = mk(1'b1, 1'b0, 12'h000, 16'h0000, 1'b1, 16'h0000, 1'b0);
        vecs[21] = mk(1'b0, 1'b1, 12'h003, 16'h003F, 1'b0, 16'h0000, 1'b0);
        vecs[22] = mk(1'b1, 1'b0, 12'h003, 16'h0000, 1'b1, 16'h0000, 1'b0);
        vecs[23] = mk(1'b0, 1'b1, 12'h005, 16'h0004, 1'b0, 16'h0000, 1'b0);
        vecs[24] = mk(1'b1, 1'b0, 12'h005, 16'h0000, 1'b1, 16'h0004, 1'b0);
        vecs[25] = mk(1'b0, 1'b1, 12'hFFF, 16'h1111, 1'b0, 16'h0000, 1'b1);
        vecs[26] = mk(1'b1, 1'b0, 12'h005, 16'h0000, 1'b1, 16'h0004, 1'b0);

        reset_n              = 1'b0;
        register_index       = '0;
        register_read        = 1'b0;
        register_write       = 1'b0;
        register_write_value = '0;
        buttons_i            = '0;
        in_vblank_i          = 1'b0;
        collision_i          = '0;

        // Reset state
        repeat (3) tick();
        check16("rst_read_value", register_read_value, 16'h0000);
        check16("rst_fwd_strobe", {15'd0, dc_register_write_o}, 16'h0000);
        check16("rst_fwd_index", {4'd0, dc_register_index_o}, 16'h0000);
        check16("rst_fwd_data", dc_register_write_value_o, 16'h0000);
        reset_n = 1'b1;
        tick();

        // Register-access vector table
        for (int i = 0; i < NVEC; i++) begin
            register_read        = vecs[i].rd;
            register_write       = vecs[i].wr;
            register_index       = vecs[i].idx;
            register_write_value = vecs[i].wdata;
            if (vecs[i].exp_fwd) exp_q.push_back({vecs[i].idx, vecs[i].wdata});
            tick();
            register_read  = 1'b0;
            register_write = 1'b0;
            if (vecs[i].chk_rd)
                check16($sformatf("vec%0d_rdata", i), register_read_value, vecs[i].exp_rd);
            check16($sformatf("vec%0d_fwd", i), {15'd0, dc_register_write_o}, {15'd0, vecs[i].exp_fwd});
        end

        // Debounce with period 4: glitch is rejected, final rise lands 2 + 4 edges later
        do_write(12'h005, 16'h0004);
        buttons_i[2] = 1'b1;
        tick();
        buttons_i[2] = 1'b0;
        tick();
        tick();
        buttons_i[2] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            do_read(12'h000, v);
            if (k == 6) check16("deb_not_early", v, 16'h0000);
            if (k == 7) check16("deb_on_time", v, 16'h0004);
        end
        rd_check("press_first", 12'h001, 16'h0004);
        rd_check("press_cleared", 12'h001, 16'h0000);

        // Period 0 behaves as 1
        do_write(12'h005, 16'h0000);
        buttons_i[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            do_read(12'h000, v);
            if (k == 3) check16("deb0_not_early", v, 16'h0004);
            if (k == 4) check16("deb0_on_time", v, 16'h0005);
        end
        rd_check("press_bit0", 12'h001, 16'h0001);

        // vblank pulses and frame counter
        do_write(12'h004, 16'h0000);
        repeat (3) begin
            in_vblank_i = 1'b1;
            repeat (3) tick();
            in_vblank_i = 1'b0;
            repeat (3) tick();
        end
        repeat (3) tick();
        rd_check("frame_3", 12'h004, 16'h0003);
        rd_check("vblank_start", 12'h002, 16'h0002);
        rd_check("vblank_cleared", 12'h002, 16'h0000);

        // Write coincides with the increment edge: the write wins
        in_vblank_i = 1'b1;
        tick();
        tick();
        do_write(12'h004, 16'h0100);
        repeat (2) tick();
        rd_check("vblank_level", 12'h002, 16'h0003);
        rd_check("frame_write_wins", 12'h004, 16'h0100);
        rd_check("vblank_level_only", 12'h002, 16'h0001);
        in_vblank_i = 1'b0;
        repeat (3) tick();

        do_write(12'h004, 16'hFFFF);
        in_vblank_i = 1'b1;
        repeat (3) tick();
        in_vblank_i = 1'b0;
        repeat (3) tick();
        rd_check("frame_wrap", 12'h004, 16'h0000);

        // Collision: event in the clearing cycle survives
        collision_i = 6'b000001;
        tick();
        collision_i = 6'b100000;
        do_read(12'h003, v);
        check16("coll_first", v, 16'h0001);
        collision_i = 6'b000000;
        rd_check("coll_kept", 12'h003, 16'h0020);
        rd_check("coll_cleared", 12'h003, 16'h0000);

        // Forwarding: payload, then local write leaves outputs held
        exp_q.push_back({12'h010, 16'hBEEF});
        do_write(12'h010, 16'hBEEF);
        check16("fwd_strobe", {15'd0, dc_register_write_o}, 16'h0001);
        check16("fwd_index", {4'd0, dc_register_index_o}, 16'h0010);
        check16("fwd_data", dc_register_write_value_o, 16'hBEEF);
        do_write(12'h003, 16'h1234);
        check16("local_no_strobe", {15'd0, dc_register_write_o}, 16'h0000);
        check16("fwd_index_hold", {4'd0, dc_register_index_o}, 16'h0010);
        check16("fwd_data_hold", dc_register_write_value_o, 16'hBEEF);

        // Reset during a debounce count and a forwarded write
        do_write(12'h005, 16'd100);
        buttons_i[3] = 1'b1;
        repeat (5) tick();
        rd_check("period_100", 12'h005, 16'd100);
        register_index       = 12'h020;
        register_write_value = 16'hCAFE;
        register_write       = 1'b1;
        tick();
        register_write = 1'b0;
        check16("pre_rst_strobe", {15'd0, dc_register_write_o}, 16'h0001);
        reset_n = 1'b0;
        #1;
        check16("rst_async_rdata", register_read_value, 16'h0000);
        check16("rst_async_strobe", {15'd0, dc_register_write_o}, 16'h0000);
        check16("rst_async_index", {4'd0, dc_register_index_o}, 16'h0000);
        check16("rst_async_data", dc_register_write_value_o, 16'h0000);
        register_index = 12'h030;
        register_write = 1'b1;
        tick();
        check16("rst_no_strobe", {15'd0, dc_register_write_o}, 16'h0000);
        register_write = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        check16("post_rst_strobe", {15'd0, dc_register_write_o}, 16'h0000);
        rd_check("post_rst_period", 12'h005, 16'h61A8);
        rd_check("post_rst_stable", 12'h000, 16'h0000);
        rd_check("post_rst_press", 12'h001, 16'h0000);

        repeat (2) tick();
        check16("fwd_queue_empty", 16'(exp_q.size()), 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/io_register_controller.md
Name: io_register_controller

Overview:
- Peripheral side of the CPU register bus: decodes ulisp register reads/writes and returns read data.
- Owns the button synchronisers and debouncers, vblank/collision event latching and a frame counter.
- Forwards writes outside its local window to display_controller.
- Sits between ulisp and display_controller in the game top level; all I/O status reads go through it.

Parameters:
- DEBOUNCE_W, 16, width of the per-button debounce counter.
- DEBOUNCE_RESET, 16'd25000, debounce period (cycles) loaded at reset; 1 ms at 25 MHz.
- LOCAL_LIMIT, 12'd8, indices below this value are local registers; indices at or above it are forwarded.

Ports:
- clk  in  1  system clock, 25 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- register_index  in  12  register address from CPU.
- register_read  in  1  read strobe, one cycle.
- register_write  in  1  write strobe, one cycle.
- register_write_value  in  16  write data.
- register_read_value  out  16  read data.
- buttons_i  in  4  raw asynchronous buttons, active-high.
- in_vblank_i  in  1  vblank level from display_controller.
- collision_i  in  6  per-frame collision flags from display_controller.
- dc_register_write_o  out  1  forwarded write strobe.
- dc_register_index_o  out  12  forwarded index.
- dc_register_write_value_o  out  16  forwarded data.

Behaviour:
- Reset (async, reset_n low):
  - All outputs 0; sync flops, debounce counters, stable state, sticky flags and frame counter 0.
  - debounce_period = DEBOUNCE_RESET.
  - Reset mid-access aborts it; no forwarded write escapes after reset asserts.
- Read latency:
  - register_read_value updates on the clock edge after register_read is sampled (1-cycle latency).
  - It holds its value when there is no read.
  - Reads of unmapped local indices (6..LOCAL_LIMIT-1) return 0.
  - Forwarded indices read 0 and have no side effect.
- Register map (local):
  - 0 RO: {12'd0, stable_buttons}.
  - 1 RC: {12'd0, press_events}. Bit sets on a 0->1 transition of the stable button.
  - 2 RC: {14'd0, vblank_start, in_vblank_sync}. vblank_start is sticky and set on the rising edge of in_vblank_sync.
  - 3 RC: {10'd0, collision_sticky}. collision_sticky |= collision_i every cycle.
  - 4 RW: frame_count[15:0]. Increments on each vblank rising edge and wraps 0xFFFF->0. A write loads the value; a write and an increment in the same cycle: the write wins.
  - 5 RW: debounce_period[DEBOUNCE_W-1:0], zero-extended on read. Writing 0 behaves as 1.
- Read-clear (RC) rule:
  - The read returns the pre-clear value, and the clear applies on the same edge.
  - If a new event occurs in the same cycle as the clearing read, the bit stays set. No event is ever lost.
- Button path, per bit:
  - 2-FF synchroniser.
  - Debounce state: stable bit plus counter.
  - When sync == stable, the counter is 0.
  - When they differ, the counter increments each cycle. On reaching debounce_period-1, stable <= sync and the counter clears.
  - Any return to equality before then clears the counter.
  - Changing debounce_period mid-count takes effect on the next compare; if counter >= new period-1, the change is accepted next cycle.
- vblank: in_vblank_i passes through a 2-FF synchroniser; the edge is detected on the synchronised signal against its delayed copy.
- Write forwarding:
  - A register_write with index >= LOCAL_LIMIT produces dc_register_write_o=1 for exactly one cycle on the next edge, with registered index and data.
  - Otherwise the strobe is 0; the index and data outputs hold their last values.
  - Local writes never forward; writes to RO/RC registers are ignored.
- Read and write asserted together: both are serviced (read returns the pre-write value).

Test Plan:
- Reset release, read idx 0,1,2,3,4 -> all 0 one cycle after each strobe; read idx 5 -> 25000.
- Write idx5=4; raise buttons_i[2], glitch 2 cycles low after 1 cycle, then hold -> stable_buttons[2] rises exactly 2 sync + 4 stable cycles after the last edge; read idx1 -> 0x0004; read again -> 0x0000.
- Pulse in_vblank_i 3 times; read idx4 -> 3, read idx2 -> bit1=1, reread -> bit1=0; write idx4=0xFFFF then one vblank -> reads 0.
- collision_i=6'b000001 one cycle, then 6'b100000 coinciding with a read of idx3 -> the read returns 0x01; the next read returns 0x20.
- Write idx 0x010, value 0xBEEF -> dc_register_write_o high for one cycle with index 0x010, data 0xBEEF; write idx 3 -> no forward.
- Assert reset_n low during a debounce count and during a forwarded write -> outputs 0 immediately, no strobe; debounce_period returns to 25000.
